// File: rtl/rv32_lsu.sv
// RV32 load/store unit: one request at a time, single word-memory access,
// then lane alignment and sign/zero extension of load data.
module rv32_lsu #(
  parameter logic [31:0] NumWords  = 32'd8096,
  parameter logic [31:0] Latency   = 32'd1,
  parameter logic [31:0] BaseAddr  = 32'h0000_0000,
  parameter int          AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [31:0]          req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [31:0]          mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [AddrWidth+1:0] off_q;
  logic [31:0]         wdata_q, rdata_q, cnt_q;
  logic                err_q;

  logic        accept, fault, f3_bad, misalign, out_of_range;
  logic [31:0] off, shifted, load_data;
  logic [15:0] half;

  assign accept = (state_q == IDLE) && req_valid_i;
  assign off    = req_addr_i - BaseAddr;

  always_comb begin
    f3_bad = !(req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = ((req_funct3_i == 3'b001 || req_funct3_i == 3'b101) && req_addr_i[0]) ||
               ((req_funct3_i == 3'b010) && (req_addr_i[1:0] != 2'b00));
    // 34-bit compare so NumWords*4 cannot wrap
    out_of_range = (req_addr_i < BaseAddr) || ({2'b00, off} >= {NumWords, 2'b00});
    fault = f3_bad || (req_we_i && req_funct3_i[2]) || misalign || out_of_range;
  end

  always_comb begin
    shifted   = mem_rdata_i >> {off_q[1:0], 3'b000};
    half      = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_data = 32'd0;
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{half[15]}}, half};
      3'b101:  load_data = {16'd0, half};
      default: load_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = fault ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 32'd0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        off_q   <= off[AddrWidth+1:0];
        wdata_q <= req_wdata_i;
        rdata_q <= 32'd0;
        err_q   <= fault;
      end
      // counter ends on the edge closing the Latency-th cycle after ISSUE
      if (state_q == ISSUE) cnt_q <= Latency - 32'd1;
      if (state_q == WAIT) begin
        if (cnt_q == 32'd0) rdata_q <= we_q ? 32'd0 : load_data;
        else                cnt_q   <= cnt_q - 32'd1;
      end
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 32'd0;
    rsp_err_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'd0;
    mem_be_o    = 4'b0000;
    case (state_q)
      IDLE: req_ready_o = 1'b1;
      ISSUE: begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_addr_o = off_q[AddrWidth+1:2];
        mem_be_o   = 4'b1111;
        if (we_q) begin
          case (f3_q[1:0])
            2'b00: begin
              mem_be_o    = 4'b0001 << off_q[1:0];
              mem_wdata_o = {4{wdata_q[7:0]}};
            end
            2'b01: begin
              mem_be_o    = off_q[1] ? 4'b1100 : 4'b0011;
              mem_wdata_o = {2{wdata_q[15:0]}};
            end
            default: mem_wdata_o = wdata_q;
          endcase
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed bench for rv32_lsu with behavioural word memories (Latency 1 and 2)
// and a response scoreboard.
module tb_rv32_lsu;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_ni, req_valid_i, req_we_i, rsp_ready_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o;
  logic [31:0] rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [12:0] mem_addr_o;
  logic [3:0]  mem_be_o;

  logic        b_req_valid, b_rsp_ready;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata, b_stage;
  logic [12:0] b_mem_addr;
  logic [3:0]  b_mem_be;

  rv32_lsu u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  rv32_lsu #(.Latency(32'd2)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err), .mem_req_o(b_mem_req),
    .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata)
  );

  logic [31:0] mem1 [0:8095];
  logic [31:0] mem2 [0:8095];

  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem1[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem1[mem_addr_o];
      end
    end
  end

  always @(posedge clk_i) begin
    if (b_mem_req && !b_mem_we) b_stage <= mem2[b_mem_addr];
    b_mem_rdata <= b_stage;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_mreq, input logic [3:0] exp_be,
                        input logic [12:0] exp_maddr, input logic [31:0] exp_mwdata,
                        input int exp_lat, input int hold);
    int   lat;
    logic seen;
    logic [3:0]  be;
    logic [12:0] maddr;
    logic [31:0] mwdata;
    rsp_t r;
    lat = 0; seen = 1'b0; be = '0; maddr = '0; mwdata = '0;
    req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wdata;
    req_valid_i = 1'b1;
    chk({tag, " req_ready"}, {31'd0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    sb_q.push_back('{exp_rdata, exp_err});
    for (int i = 1; i <= 20; i++) begin
      if (mem_req_o) begin
        seen = 1'b1; be = mem_be_o; maddr = mem_addr_o; mwdata = mem_wdata_o;
        chk({tag, " mem_we"}, {31'd0, mem_we_o}, {31'd0, we});
      end
      if (rsp_valid_o) begin
        lat = i;
        break;
      end
      @(negedge clk_i);
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " mem_req seen"}, {31'd0, seen}, {31'd0, exp_mreq});
    if (exp_mreq) begin
      chk({tag, " mem_be"}, {28'd0, be}, {28'd0, exp_be});
      chk({tag, " mem_addr"}, {19'd0, maddr}, {19'd0, exp_maddr});
      chk({tag, " mem_wdata"}, mwdata, exp_mwdata);
    end
    if (lat == 0) return;
    for (int h = 0; h < hold; h++) begin
      chk({tag, " hold valid"}, {31'd0, rsp_valid_o}, 32'd1);
      chk({tag, " hold rdata"}, rsp_rdata_o, exp_rdata);
      chk({tag, " hold req_ready"}, {31'd0, req_ready_o}, 32'd0);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    r = sb_q.pop_front();
    chk({tag, " rdata"}, rsp_rdata_o, r.rdata);
    chk({tag, " err"}, {31'd0, rsp_err_o}, {31'd0, r.err});
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk({tag, " back to idle"}, {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0; rsp_ready_i = 1'b0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b0;
    mem1[8] = 32'd0;
    mem2[5] = 32'h1234_5678;
    repeat (2) @(negedge clk_i);
    chk("reset ready/valid/err", {29'd0, req_ready_o, rsp_valid_o, rsp_err_o}, 32'b100);
    chk("reset rdata", rsp_rdata_o, 32'd0);
    chk("reset mem ctl", {26'd0, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
    chk("reset mem addr/wdata", {19'd0, mem_addr_o} | mem_wdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    //     tag        we   f3      addr          wdata          rdata          err mreq be       maddr   mwdata         lat hold
    access("SW 10",   1, 3'b010, 32'h10,     32'hDEADBEEF, 32'h0,         0, 1, 4'b1111, 13'd4,    32'hDEADBEEF, 3, 0);
    access("LW 10",   0, 3'b010, 32'h10,     32'h0,        32'hDEADBEEF,  0, 1, 4'b1111, 13'd4,    32'h0,        3, 0);
    access("SB 13",   1, 3'b000, 32'h13,     32'h80,       32'h0,         0, 1, 4'b1000, 13'd4,    32'h80808080, 3, 0);
    access("LB 13",   0, 3'b000, 32'h13,     32'h0,        32'hFFFFFF80,  0, 1, 4'b1111, 13'd4,    32'h0,        3, 0);
    access("LBU 13",  0, 3'b100, 32'h13,     32'h0,        32'h00000080,  0, 1, 4'b1111, 13'd4,    32'h0,        3, 0);
    access("LBU 12",  0, 3'b100, 32'h12,     32'h0,        32'h000000AD,  0, 1, 4'b1111, 13'd4,    32'h0,        3, 0);
    access("LB 10",   0, 3'b000, 32'h10,     32'h0,        32'hFFFFFFEF,  0, 1, 4'b1111, 13'd4,    32'h0,        3, 0);
    access("SH 22",   1, 3'b001, 32'h22,     32'h8001,     32'h0,         0, 1, 4'b1100, 13'd8,    32'h80018001, 3, 0);
    access("LH 22",   0, 3'b001, 32'h22,     32'h0,        32'hFFFF8001,  0, 1, 4'b1111, 13'd8,    32'h0,        3, 0);
    access("LHU 22",  0, 3'b101, 32'h22,     32'h0,        32'h00008001,  0, 1, 4'b1111, 13'd8,    32'h0,        3, 0);
    access("LH 20",   0, 3'b001, 32'h20,     32'h0,        32'h00000000,  0, 1, 4'b1111, 13'd8,    32'h0,        3, 0);
    access("SW last", 1, 3'b010, 32'h7E7C,   32'h0BADF00D, 32'h0,         0, 1, 4'b1111, 13'd8095, 32'h0BADF00D, 3, 0);
    access("LW last", 0, 3'b010, 32'h7E7C,   32'h0,        32'h0BADF00D,  0, 1, 4'b1111, 13'd8095, 32'h0,        3, 0);
    access("LW 11",   0, 3'b010, 32'h11,     32'h0,        32'h0,         1, 0, 4'b0,    13'd0,    32'h0,        1, 0);
    access("LHU 21",  0, 3'b101, 32'h21,     32'h0,        32'h0,         1, 0, 4'b0,    13'd0,    32'h0,        1, 0);
    access("SB oor",  1, 3'b000, 32'h7E80,   32'h55,       32'h0,         1, 0, 4'b0,    13'd0,    32'h0,        1, 0);
    access("f3 011",  0, 3'b011, 32'h0,      32'h0,        32'h0,         1, 0, 4'b0,    13'd0,    32'h0,        1, 0);
    access("SBU",     1, 3'b100, 32'h10,     32'h0,        32'h0,         1, 0, 4'b0,    13'd0,    32'h0,        1, 0);
    access("LW hold", 0, 3'b010, 32'h10,     32'h0,        32'h80ADBEEF,  0, 1, 4'b1111, 13'd4,    32'h0,        3, 5);

    // Reset during WAIT: no response may follow
    req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h10; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst ready/valid/err", {29'd0, req_ready_o, rsp_valid_o, rsp_err_o}, 32'b100);
    chk("midrst rdata", rsp_rdata_o, 32'd0);
    chk("midrst mem", {26'd0, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("midrst no rsp", {31'd0, rsp_valid_o}, 32'd0);
    end

    // Latency-2 instance
    begin
      int   lat;
      rsp_t r;
      lat = 0;
      req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h14; b_req_valid = 1'b1;
      @(negedge clk_i);
      b_req_valid = 1'b0;
      sb_q.push_back('{32'h1234_5678, 1'b0});
      for (int i = 1; i <= 20; i++) begin
        if (b_rsp_valid) begin
          lat = i;
          break;
        end
        @(negedge clk_i);
      end
      chk("lat2 latency", lat, 4);
      if (lat != 0) begin
        r = sb_q.pop_front();
        chk("lat2 rdata", b_rsp_rdata, r.rdata);
        chk("lat2 err", {31'd0, b_rsp_err}, {31'd0, r.err});
        b_rsp_ready = 1'b1;
        @(negedge clk_i);
        b_rsp_ready = 1'b0;
        chk("lat2 idle", {30'd0, b_rsp_valid, b_req_ready}, 32'd1);
      end
    end

    chk("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32_lsu.md
Name: rv32_lsu

Overview:
- Load/store unit sitting directly upstream of rv32_data_memory; drives one of its ports.
- Accepts one RV32 load/store per handshake from the core's memory stage and converts byte addresses into word address, byte enables and lane-replicated write data.
- Issues a single memory request, waits the memory read latency, then aligns and sign/zero-extends load data.
- Returns one response per request through a valid/ready handshake; misaligned, out-of-range and illegal accesses are flagged as errors.

Parameters:
NumWords, 32'd8096, words in the attached data memory
Latency, 32'd1, memory read latency in cycles (>=1); must match the memory instance
BaseAddr, 32'h0000_0000, byte address mapped to memory word 0
AddrWidth, (NumWords>1)?$clog2(NumWords):1, derived; do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  1  core request valid
req_ready_o  out  1  LSU can accept a request
req_we_i  in  1  1=store, 0=load
req_funct3_i  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data (LSB-aligned)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  core accepts response
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  access fault (misaligned/out-of-range/illegal funct3)
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  AddrWidth  memory word address
mem_wdata_o  out  32  lane-replicated write data
mem_be_o  out  4  byte enables
mem_rdata_i  in  32  memory read data

Behaviour:
- Interface: one clock clk_i; reset rst_ni is synchronous and active-low.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (rst_ni=0 at a clk_i edge): state=IDLE, latency counter=0. Outputs: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
- Reset mid-operation aborts the operation. No response is produced for it. A memory request already driven is not retracted.
- IDLE: req_ready_o=1. On req_valid_i&req_ready_o, register we, funct3, addr offset and wdata.
  - Fault: go to RESP with err=1, rdata=0; no memory request.
  - No fault: go to ISSUE.
- Fault conditions:
  - funct3 not in {000,001,010,100,101};
  - store with funct3 100 or 101;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - addr<BaseAddr or (addr-BaseAddr)>=NumWords*4.
- ISSUE (exactly one cycle): drive memory outputs, then go to WAIT.
  - mem_req_o=1, mem_we_o=we.
  - mem_addr_o=(addr-BaseAddr)[AddrWidth+1:2].
  - Stores: B gives be=1<<addr[1:0], wdata={4{wdata[7:0]}}. H gives be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}. W gives be=1111, wdata=wdata.
  - Loads: be=1111, wdata=0.
  - Memory outputs are 0 in every state other than ISSUE.
- WAIT: counter counts Latency cycles after ISSUE; mem_rdata_i is sampled on the edge ending the Latency-th cycle after ISSUE.
  - Loads: select the lane at offset addr[1:0]. B/BU take byte rdata[8*off+:8]; H/HU take halfword rdata[16*addr[1]+:16]. B/H sign-extend; BU/HU zero-extend.
  - Stores: rdata=0; same WAIT duration applies, giving uniform timing.
  - Then go to RESP.
- RESP: rsp_valid_o=1 and rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1 at a clock edge, then go to IDLE. req_ready_o=0 in ISSUE, WAIT and RESP.
- Timing:
  - Accept-to-rsp_valid latency: 2+Latency cycles for a good access, 1 cycle for a fault.
  - Maximum throughput: one access per 3+Latency cycles.
  - No request is accepted in the same cycle a response completes.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_be_o=1111, mem_addr_o=4; load response rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after accept (Latency=1).
- SB 0x13 data 0x80 -> be=1000, mem_wdata_o=0x80808080. Then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
- SH 0x22 data 0x8001 then LH 0x22 -> be=1100, rdata=0xFFFF8001; LHU 0x22 -> 0x00008001.
- LW 0x11, LHU 0x21, SB 0x7E80 (NumWords=8096), funct3=011 -> each err=1, rdata=0, mem_req_o never asserted, rsp_valid 1 cycle after accept.
- LW with rsp_ready_i held 0 for 5 cycles -> rsp_valid_o/rdata stable 5 cycles, req_ready_o=0 throughout; IDLE one cycle after ready.
- rst_ni=0 during WAIT -> next cycle all outputs at reset values, req_ready_o=1, no response. Latency=2 build: LW response 4 cycles after accept.
